// File: rtl/ceyloniac_ram_arb_pkg.sv
// Shared types and constants for the ceyloniac RAM arbiter.
package ceyloniac_ram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Arbiter state: free round-robin or exclusive external ownership
  typedef enum logic {
    ARB_S_ARB    = 1'b0,
    ARB_S_LOCKED = 1'b1
  } arb_state_e;

  // Requester identity, used for last-grant history and read ownership
  typedef enum logic {
    MASTER_PROC = 1'b0,
    MASTER_EXT  = 1'b1
  } master_e;

  // One-deep read return tracker
  typedef struct packed {
    logic    pending;
    master_e owner;
  } rd_track_t;

  // The master that did not win last time
  function automatic master_e other_master(input master_e m);
    return (m == MASTER_PROC) ? MASTER_EXT : MASTER_PROC;
  endfunction

endpackage

// File: rtl/ceyloniac_rr_arb2.sv
// Two-way round-robin pick with a last-grant register and a force-E override.
module ceyloniac_rr_arb2
  import ceyloniac_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_p,
  input  logic req_e,
  input  logic force_e,
  output logic gnt_p_c,
  output logic gnt_e_c
);

  master_e last_gnt;
  master_e favoured;

  // Under contention the master not granted last time wins unless E is forced
  assign favoured = other_master(last_gnt);

  // Same-cycle grant decision
  always_comb begin
    gnt_p_c = 1'b0;
    gnt_e_c = 1'b0;
    if (req_p && req_e) begin
      if (force_e || (favoured == MASTER_EXT)) begin
        gnt_e_c = 1'b1;
      end else begin
        gnt_p_c = 1'b1;
      end
    end else if (req_p) begin
      gnt_p_c = 1'b1;
    end else if (req_e) begin
      gnt_e_c = 1'b1;
    end
  end

  // Remember who was granted; reset to E so P wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= MASTER_EXT;
    end else if (gnt_p_c) begin
      last_gnt <= MASTER_PROC;
    end else if (gnt_e_c) begin
      last_gnt <= MASTER_EXT;
    end
  end

endmodule

// File: rtl/ceyloniac_ram_arbiter.sv
// Shares one synchronous RAM port between the processor and an external host.
module ceyloniac_ram_arbiter
  import ceyloniac_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // processor requester
  input  logic                      proc_req,
  input  logic                      proc_we,
  input  logic [RAM_ADDR_WIDTH-1:0] proc_addr,
  input  logic [RAM_DATA_WIDTH-1:0] proc_wdata,
  output logic                      proc_gnt,
  output logic                      proc_rvalid,
  output logic [RAM_DATA_WIDTH-1:0] proc_rdata,
  // external loader / debug requester
  input  logic                      ext_req,
  input  logic                      ext_we,
  input  logic [RAM_ADDR_WIDTH-1:0] ext_addr,
  input  logic [RAM_DATA_WIDTH-1:0] ext_wdata,
  output logic                      ext_gnt,
  output logic                      ext_rvalid,
  output logic [RAM_DATA_WIDTH-1:0] ext_rdata,
  input  logic                      ext_lock,
  output logic                      ext_locked,
  // RAM port
  output logic                      ram_enable,
  output logic                      ram_write_enable,
  output logic                      ram_read_enable,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_write_data,
  input  logic [RAM_DATA_WIDTH-1:0] ram_read_data,
  // debug counters
  output logic [CNT_WIDTH-1:0]      proc_gnt_cnt,
  output logic [CNT_WIDTH-1:0]      ext_gnt_cnt
);

  arb_state_e state;
  rd_track_t  rd_q;

  logic req_p_c;
  logic req_e_c;
  logic gnt_p_c;
  logic gnt_e_c;
  logic sel_we_c;
  logic rd_issue_c;

  // Lock follows ext_lock edge by edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_S_ARB;
    end else begin
      case (state)
        ARB_S_ARB:    if (ext_lock)  state <= ARB_S_LOCKED;
        ARB_S_LOCKED: if (!ext_lock) state <= ARB_S_ARB;
        default:      state <= ARB_S_ARB;
      endcase
    end
  end

  assign ext_locked = (state == ARB_S_LOCKED);

  // Requests are masked during reset; P is shut out entirely while locked
  assign req_p_c = rst_n & proc_req & (state == ARB_S_ARB);
  assign req_e_c = rst_n & ext_req;

  ceyloniac_rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_p   (req_p_c),
    .req_e   (req_e_c),
    .force_e (ext_lock),
    .gnt_p_c (gnt_p_c),
    .gnt_e_c (gnt_e_c)
  );

  assign proc_gnt = gnt_p_c;
  assign ext_gnt  = gnt_e_c;

  // Steer the granted master onto the RAM port; idle port drives zeros
  always_comb begin
    sel_we_c       = 1'b0;
    ram_addr       = '0;
    ram_write_data = '0;
    if (gnt_p_c) begin
      sel_we_c       = proc_we;
      ram_addr       = proc_addr;
      ram_write_data = proc_wdata;
    end else if (gnt_e_c) begin
      sel_we_c       = ext_we;
      ram_addr       = ext_addr;
      ram_write_data = ext_wdata;
    end
  end

  assign ram_enable       = gnt_p_c | gnt_e_c;
  assign ram_write_enable = ram_enable & sel_we_c;
  assign ram_read_enable  = ram_enable & ~sel_we_c;
  assign rd_issue_c       = ram_read_enable;

  // Track the owner of the read whose data returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q.pending <= 1'b0;
      rd_q.owner   <= MASTER_PROC;
    end else begin
      rd_q.pending <= rd_issue_c;
      if (rd_issue_c) begin
        rd_q.owner <= gnt_e_c ? MASTER_EXT : MASTER_PROC;
      end
    end
  end

  // Return data only to the owner; the other side sees zero
  assign proc_rvalid = rd_q.pending & (rd_q.owner == MASTER_PROC);
  assign ext_rvalid  = rd_q.pending & (rd_q.owner == MASTER_EXT);
  assign proc_rdata  = proc_rvalid ? ram_read_data : '0;
  assign ext_rdata   = ext_rvalid  ? ram_read_data : '0;

  // Saturating per-master grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_gnt_cnt <= '0;
      ext_gnt_cnt  <= '0;
    end else begin
      if (gnt_p_c && (proc_gnt_cnt != '1)) begin
        proc_gnt_cnt <= proc_gnt_cnt + CNT_WIDTH'(1);
      end
      if (gnt_e_c && (ext_gnt_cnt != '1)) begin
        ext_gnt_cnt <= ext_gnt_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ceyloniac_ram_arbiter.sv
// Directed bench for ceyloniac_ram_arbiter with a small synchronous RAM model.
module tb_ceyloniac_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        proc_req, proc_we;
  logic [15:0] proc_addr;
  logic [31:0] proc_wdata;
  logic        proc_gnt, proc_rvalid;
  logic [31:0] proc_rdata;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ext_lock, ext_locked;
  logic        ram_enable, ram_write_enable, ram_read_enable;
  logic [15:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic [15:0] proc_gnt_cnt, ext_gnt_cnt;

  // narrow-counter instance outputs
  logic        d4_proc_gnt, d4_proc_rvalid, d4_ext_gnt, d4_ext_rvalid, d4_ext_locked;
  logic [31:0] d4_proc_rdata, d4_ext_rdata, d4_ram_write_data;
  logic        d4_ram_enable, d4_ram_write_enable, d4_ram_read_enable;
  logic [15:0] d4_ram_addr;
  logic [3:0]  d4_proc_gnt_cnt, d4_ext_gnt_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];

  ceyloniac_ram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ext_lock(ext_lock), .ext_locked(ext_locked),
    .ram_enable(ram_enable), .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .proc_gnt_cnt(proc_gnt_cnt), .ext_gnt_cnt(ext_gnt_cnt)
  );

  ceyloniac_ram_arbiter #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(d4_proc_gnt), .proc_rvalid(d4_proc_rvalid), .proc_rdata(d4_proc_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(d4_ext_gnt), .ext_rvalid(d4_ext_rvalid), .ext_rdata(d4_ext_rdata),
    .ext_lock(ext_lock), .ext_locked(d4_ext_locked),
    .ram_enable(d4_ram_enable), .ram_write_enable(d4_ram_write_enable), .ram_read_enable(d4_ram_read_enable),
    .ram_addr(d4_ram_addr), .ram_write_data(d4_ram_write_data), .ram_read_data(ram_read_data),
    .proc_gnt_cnt(d4_proc_gnt_cnt), .ext_gnt_cnt(d4_ext_gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on strobe, read data one cycle after read strobe
  always @(posedge clk) begin
    if (ram_enable && ram_write_enable) mem[ram_addr[7:0]] <= ram_write_data;
    if (ram_enable && ram_read_enable)  ram_read_data <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    proc_req = 1'b0; proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;
    ext_req  = 1'b0; ext_we  = 1'b0; ext_addr  = '0; ext_wdata  = '0;
  endtask

  task automatic p_drive(input logic we, input logic [15:0] a, input logic [31:0] d);
    proc_req = 1'b1; proc_we = we; proc_addr = a; proc_wdata = d;
  endtask

  task automatic e_drive(input logic we, input logic [15:0] a, input logic [31:0] d);
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  task automatic reset_pulse();
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ext_lock = 1'b0; idle();

    // ---- outputs quiet during reset even with a request present
    repeat (2) @(negedge clk);
    p_drive(1'b1, 16'h0010, 32'h1234_5678); #1;
    chk("rst_proc_gnt", proc_gnt, 0);
    chk("rst_ram_en", ram_enable, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_write_data, 0);
    chk("rst_proc_rvalid", proc_rvalid, 0);
    chk("rst_locked", ext_locked, 0);
    chk("rst_pcnt", proc_gnt_cnt, 0);
    chk("rst_ecnt", ext_gnt_cnt, 0);
    idle();
    @(negedge clk); rst_n = 1'b1;

    // ---- P write then P read
    @(negedge clk); p_drive(1'b1, 16'h0010, 32'hDEAD_BEEF); #1;
    chk("wr_proc_gnt", proc_gnt, 1);
    chk("wr_ext_gnt", ext_gnt, 0);
    chk("wr_ram_we", ram_write_enable, 1);
    chk("wr_ram_addr", ram_addr, 32'h10);
    chk("wr_ram_wdata", ram_write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_no_rvalid", proc_rvalid, 0);
    p_drive(1'b0, 16'h0010, 32'h0); #1;
    chk("rd_proc_gnt", proc_gnt, 1);
    chk("rd_ram_re", ram_read_enable, 1);
    chk("rd_ram_we", ram_write_enable, 0);
    @(negedge clk); idle(); #1;
    chk("rd_proc_rvalid", proc_rvalid, 1);
    chk("rd_proc_rdata", proc_rdata, 32'hDEAD_BEEF);
    chk("rd_ext_rvalid", ext_rvalid, 0);
    chk("rd_ext_rdata", ext_rdata, 0);
    chk("idle_ram_en", ram_enable, 0);
    chk("idle_ram_addr", ram_addr, 0);
    @(negedge clk);
    chk("rd_rvalid_drop", proc_rvalid, 0);
    chk("rd_pcnt", proc_gnt_cnt, 2);

    // ---- preload two words, then reset the arbiter
    p_drive(1'b1, 16'h0001, 32'h1111_1111);
    @(negedge clk); idle(); e_drive(1'b1, 16'h0002, 32'h2222_2222); #1;
    chk("pre_ext_gnt", ext_gnt, 1);
    reset_pulse();

    // ---- contention: both read for 4 cycles, expect P,E,P,E
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1 || i == 3) begin
        chk("cont_p_rvalid", proc_rvalid, 1);
        chk("cont_p_rdata", proc_rdata, 32'h1111_1111);
        chk("cont_e_quiet", ext_rvalid, 0);
      end else if (i == 2) begin
        chk("cont_e_rvalid", ext_rvalid, 1);
        chk("cont_e_rdata", ext_rdata, 32'h2222_2222);
        chk("cont_p_rdata0", proc_rdata, 0);
      end
      p_drive(1'b0, 16'h0001, 32'h0);
      e_drive(1'b0, 16'h0002, 32'h0); #1;
      chk("cont_pgnt", proc_gnt, (i % 2 == 0) ? 1 : 0);
      chk("cont_egnt", ext_gnt, (i % 2 == 1) ? 1 : 0);
    end
    @(negedge clk); idle();
    chk("cont_last_e_rvalid", ext_rvalid, 1);
    chk("cont_last_e_rdata", ext_rdata, 32'h2222_2222);
    chk("cont_last_p_rvalid", proc_rvalid, 0);
    chk("cont_pcnt", proc_gnt_cnt, 2);
    chk("cont_ecnt", ext_gnt_cnt, 2);

    // ---- lock: E burst-writes 3 words while P waits 6 cycles
    @(negedge clk); ext_lock = 1'b1;
    p_drive(1'b0, 16'h0010, 32'h0); e_drive(1'b1, 16'h0100, 32'hA000_0000); #1;
    chk("lk0_egnt", ext_gnt, 1);
    chk("lk0_pgnt", proc_gnt, 0);
    chk("lk0_locked", ext_locked, 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); e_drive(1'b1, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i)); #1;
      chk("lk_egnt", ext_gnt, 1);
      chk("lk_pgnt", proc_gnt, 0);
      chk("lk_locked", ext_locked, 1);
      chk("lk_wdata", ram_write_data, 32'hA000_0000 + 32'(i));
    end
    @(negedge clk); ext_req = 1'b0; #1;
    chk("lk3_pgnt", proc_gnt, 0);
    chk("lk3_ram_en", ram_enable, 0);
    @(negedge clk); ext_lock = 1'b0; #1;
    chk("lk4_pgnt_still_locked", proc_gnt, 0);
    chk("lk4_locked", ext_locked, 1);
    @(negedge clk); #1;
    chk("lk5_pgnt", proc_gnt, 1);
    chk("lk5_locked", ext_locked, 0);
    @(negedge clk); idle();
    chk("lk_p_rvalid", proc_rvalid, 1);
    chk("lk_p_rdata", proc_rdata, 32'hDEAD_BEEF);
    chk("lk_pcnt", proc_gnt_cnt, 3);
    chk("lk_ecnt", ext_gnt_cnt, 5);

    // ---- P read granted on the cycle the lock rises
    @(negedge clk); ext_lock = 1'b1; p_drive(1'b0, 16'h0101, 32'h0); #1;
    chk("lkrd_pgnt", proc_gnt, 1);
    @(negedge clk); idle();
    chk("lkrd_locked", ext_locked, 1);
    chk("lkrd_p_rvalid", proc_rvalid, 1);
    chk("lkrd_p_rdata", proc_rdata, 32'hA000_0001);
    @(negedge clk); ext_lock = 1'b0;
    chk("lkrd_rvalid_drop", proc_rvalid, 0);
    @(negedge clk);
    chk("lkrd_unlocked", ext_locked, 0);

    // ---- reset right after a granted E read drops the read
    e_drive(1'b0, 16'h0002, 32'h0); #1;
    chk("rr_egnt", ext_gnt, 1);
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    chk("rr_ext_rvalid_in_rst", ext_rvalid, 0);
    chk("rr_ext_rdata_in_rst", ext_rdata, 0);
    chk("rr_pcnt", proc_gnt_cnt, 0);
    chk("rr_ecnt", ext_gnt_cnt, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rr_ext_rvalid_after", ext_rvalid, 0);
    @(negedge clk);
    chk("rr_ext_rvalid_later", ext_rvalid, 0);
    p_drive(1'b0, 16'h0001, 32'h0); e_drive(1'b0, 16'h0002, 32'h0); #1;
    chk("rr_first_pgnt", proc_gnt, 1);
    chk("rr_first_egnt", ext_gnt, 0);

    // ---- counter saturation on the 4-bit instance
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 14) chk("sat_d4_14", d4_proc_gnt_cnt, 4'hE);
      if (i == 15) begin
        chk("sat_d4_15", d4_proc_gnt_cnt, 4'hF);
        chk("sat_wide_15", proc_gnt_cnt, 15);
      end
      p_drive(1'b1, 16'h0040 + 16'(i), 32'(i));
    end
    @(negedge clk); idle();
    chk("sat_d4_hold", d4_proc_gnt_cnt, 4'hF);
    chk("sat_wide_20", proc_gnt_cnt, 20);
    chk("sat_d4_ecnt", d4_ext_gnt_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ceyloniac_ram_arbiter.md
Name: ceyloniac_ram_arbiter

Overview:
- Shares the single port of ceyloniac_sync_ram between two requesters: processor (P) and external loader/debug host (E).
- Per-cycle request/grant handshake with two-master round-robin arbitration and an external lock mode for exclusive burst access.
- Routes 1-cycle-latency read data back to the requester that issued the read, with a read-valid strobe.
- Keeps saturating per-master grant counters for bring-up and debug.

Parameters:
- RAM_DATA_WIDTH, 32, data width of RAM and both requester ports
- RAM_ADDR_WIDTH, 16, address width of RAM and both requester ports
- CNT_WIDTH, 16, width of each grant counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- proc_req  in  1  P requests an access this cycle
- proc_we  in  1  1 = write, 0 = read
- proc_addr  in  RAM_ADDR_WIDTH  P address
- proc_wdata  in  RAM_DATA_WIDTH  P write data
- proc_gnt  out  1  P access accepted this cycle
- proc_rvalid  out  1  proc_rdata valid (one cycle after a granted P read)
- proc_rdata  out  RAM_DATA_WIDTH  P read data
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata  as P, for E
- ext_lock  in  1  E requests exclusive ownership
- ext_locked  out  1  arbiter is in the LOCKED state
- ram_enable, ram_write_enable, ram_read_enable  out  1 each  RAM strobes
- ram_addr  out  RAM_ADDR_WIDTH  RAM address
- ram_write_data  out  RAM_DATA_WIDTH  RAM write data
- ram_read_data  in  RAM_DATA_WIDTH  RAM read data, valid one cycle after a read strobe
- proc_gnt_cnt, ext_gnt_cnt  out  CNT_WIDTH each  saturating grant counters

Behaviour:
- States: ARB, LOCKED.
  - ARB -> LOCKED on a clock edge where ext_lock=1.
  - LOCKED -> ARB on a clock edge where ext_lock=0.
  - ext_locked = (state == LOCKED).
- Grant is combinational in the same cycle as the request. The RAM strobes, address and data come from the granted master in that cycle. Exactly one gnt is high, or none.
- ARB selection:
  - Only one requester active: that requester is granted.
  - Both active and ext_lock=1: E is granted.
  - Both active otherwise: the master not recorded in last_gnt is granted.
  - last_gnt updates on every grant.
- LOCKED: proc_gnt is forced to 0. E is granted whenever ext_req=1.
- RAM strobes:
  - ram_enable = any gnt.
  - ram_write_enable = gnt & we.
  - ram_read_enable = gnt & ~we.
  - With no grant, all strobes are 0 and ram_addr/ram_write_data hold the value 0.
- Read return:
  - A 1-deep pipeline register holds {rd_pending, rd_owner}.
  - The cycle after a granted read, the owner's rvalid=1 and its rdata equals ram_read_data.
  - The non-owner's rdata is 0 and its rvalid is 0.
  - Writes never raise rvalid.
  - Back-to-back reads, alternating owners, are supported at one per cycle.
- Lock entry with a read in flight: the pending P rvalid still completes the next cycle; it is never dropped by the state change.
- Counters: increment on the owner's gnt and saturate at all-ones with no wrap.
- Reset (asynchronous assert, synchronous release):
  - state=ARB, last_gnt=E (so P wins the first contention), rd_pending=0, counters=0.
  - All gnt, rvalid, rdata, RAM strobes, address and data outputs are 0 while rst_n=0.
  - Reset during a pending read discards that read; no rvalid is issued after release.

Decomposition:
- Package ceyloniac_ram_arb_pkg:
  - state encodings ARB_S_ARB=1'b0, ARB_S_LOCKED=1'b1
  - master IDs MASTER_PROC=1'b0, MASTER_EXT=1'b1
- One natural sub-module: ceyloniac_rr_arb2, the combinational two-way round-robin pick with last_gnt register and a force-E input.
- Top level instantiates the arbiter and ceyloniac_sync_ram side by side. This block does not instantiate the RAM.

Test Plan:
- Reset, then P write addr 0x0010 data 0xDEADBEEF, then P read 0x0010 -> proc_gnt=1 both cycles; proc_rvalid=1 one cycle after the read with proc_rdata=0xDEADBEEF; ext_rvalid=0 throughout.
- Both requesting reads on 4 consecutive cycles, P addr 0x0001, E addr 0x0002 -> grants P,E,P,E; rvalid and rdata go to the matching owner each following cycle; proc_gnt_cnt=2, ext_gnt_cnt=2.
- ext_lock=1 while P holds its request 6 cycles and E writes 3 words 0x0100..0x0102 -> proc_gnt=0 during LOCKED; after ext_lock=0, P is granted the cycle after LOCKED exits.
- P read granted in the cycle ext_lock rises -> proc_rvalid still asserted next cycle with correct data; ext_locked=1 from that same edge.
- rst_n pulsed low for 1 cycle immediately after a granted E read -> ext_rvalid stays 0; counters=0; first contention after release grants P.
- CNT_WIDTH=4 with P alone requesting 20 cycles -> proc_gnt_cnt reaches 0xF and holds.
